mul_pipe_unit: RTL and testbench

Three-stage pipelined RV32M multiply execution unit. Sits directly downstream of the issue stage and wraps the team's unsigned 32x32 combinational array multiplier. Converts signed and mixed-sign operands to magnitudes before the array, registers the 64-bit product, and applies sign correction and high/low selection at the back end. Results carry a tag into writeback/ROB through a valid/ready handshake, and the unit supports a pipeline-wide flush.

---
 rtl/mul_pipe_unit.sv | 125 ++++++++++++
 tb/tb_mul_pipe_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_pipe_unit.sv
// Three-stage RV32M multiply unit: operand magnitudes, unsigned array product, sign fix and half select.
// Optional completed-operation counter o_mul_count is built when MUL_PERF_CNT_EN is defined.
module mul_pipe_unit #(
    parameter int TAG_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [31:0]      i_rs1,
    input  logic [31:0]      i_rs2,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_result,
    output logic [TAG_W-1:0] o_tag
`ifdef MUL_PERF_CNT_EN
    ,
    output logic [31:0]      o_mul_count
`endif
);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    // Two's-complement negation wraps 0x80000000 onto itself, which is exactly its magnitude.
    function automatic logic [31:0] magnitude(input logic signed [31:0] v, input logic is_signed);
        logic signed [31:0] n;
        n = -v;
        return (is_signed && v[31]) ? n : v;
    endfunction

    function automatic logic [63:0] apply_sign(input logic [63:0] p, input logic neg);
        logic signed [63:0] s;
        s = neg ? -$signed(p) : $signed(p);
        return s;
    endfunction

    function automatic logic [31:0] select_half(input logic [63:0] p, input logic [1:0] op);
        return (op == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    logic             adv;
    logic             accept;
    logic             a_signed;
    logic             b_signed;
    logic             neg_in;

    logic             vld_p1, vld_p2, vld_p3;
    logic [31:0]      mag_a_p1, mag_b_p1;
    logic             neg_p1, neg_p2;
    logic [1:0]       op_p1, op_p2;
    logic [TAG_W-1:0] tag_p1, tag_p2;
    logic [63:0]      prod_p2;
    logic [63:0]      array_prod;

    // A full output register that is not being taken stalls the whole pipe.
    assign adv      = ~vld_p3 | i_ready;
    assign o_ready  = adv & ~i_flush;
    assign accept   = i_valid & o_ready;
    assign o_valid  = vld_p3;

    assign a_signed = (i_op == OP_MULH) | (i_op == OP_MULHSU);
    assign b_signed = (i_op == OP_MULH);
    assign neg_in   = (a_signed & i_rs1[31]) ^ (b_signed & i_rs2[31]);

    assign array_prod = {32'b0, mag_a_p1} * {32'b0, mag_b_p1};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (i_flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (adv) begin
            vld_p1 <= accept;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (adv) begin
            // Stage 1: operand magnitudes and result sign
            mag_a_p1 <= magnitude(i_rs1, a_signed);
            mag_b_p1 <= magnitude(i_rs2, b_signed);
            neg_p1   <= neg_in;
            op_p1    <= i_op;
            tag_p1   <= i_tag;
            // Stage 2: unsigned 64-bit array product
            prod_p2  <= array_prod;
            neg_p2   <= neg_p1;
            op_p2    <= op_p1;
            tag_p2   <= tag_p1;
        end
    end

    // Stage 3: sign correction and high/low selection into the output register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_result <= 32'd0;
            o_tag    <= '0;
        end else if (adv && vld_p2) begin
            o_result <= select_half(apply_sign(prod_p2, neg_p2), op_p2);
            o_tag    <= tag_p2;
        end
    end

`ifdef MUL_PERF_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mul_count <= 32'd0;
        end else if (vld_p3 && i_ready && !i_flush) begin
            o_mul_count <= o_mul_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Directed and randomized bench for mul_pipe_unit with a queue scoreboard fed from an independent signed model.
// Counter checks are included when MUL_PERF_CNT_EN is defined.
module tb_mul_pipe_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic [5:0]  i_tag;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic [5:0]  o_tag;
`ifdef MUL_PERF_CNT_EN
    logic [31:0] mul_count;
`endif

    mul_pipe_unit #(.TAG_W(6)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_flush  (i_flush),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_tag    (i_tag),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_tag    (o_tag)
`ifdef MUL_PERF_CNT_EN
        ,
        .o_mul_count (mul_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] res;
    } exp_t;

    exp_t        q[$];
    exp_t        head;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFF0000};
    logic [31:0] exp1;

    // Reference: sign- or zero-extend to 64 bits and multiply modulo 2^64.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        sa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        sb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = sa * sb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Evaluated at the falling edge: retire, flush and accept decisions for the coming rising edge.
    task automatic scoreboard();
        if (!i_rst_n) begin
            q.delete();
        end else begin
            if (o_valid && i_ready && !i_flush) begin
                checks++;
                assert (q.size() > 0) else begin
                    errors++;
                    $error("FAIL spurious_output observed=%0h expected=none", o_result);
                end
                if (q.size() > 0) begin
                    head = q.pop_front();
                    check("sb_result", o_result, head.res);
                    check("sb_tag", o_tag, head.tag);
                end
            end
            if (i_flush) q.delete();
            if (i_valid && o_ready) q.push_back({i_tag, model(i_op, i_rs1, i_rs2)});
        end
    endtask

    task automatic step();
        @(negedge i_clk);
        scoreboard();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
        i_valid = 1'b1;
        i_op    = op;
        i_rs1   = a;
        i_rs2   = b;
        i_tag   = tag;
    endtask

    task automatic run_one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] tag, input logic [31:0] exp);
        drive(op, a, b, tag);
        step();
        i_valid = 1'b0;
        check("lat_c1_valid", o_valid, 0);
        step();
        check("lat_c2_valid", o_valid, 0);
        step();
        check("lat_c3_valid", o_valid, 1);
        check("lat_c3_result", o_result, exp);
        check("lat_c3_tag", o_tag, tag);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_op    = 2'b00;
        i_rs1   = 32'h0;
        i_rs2   = 32'h0;
        i_tag   = 6'h0;
        repeat (3) step();
        check("rst_o_valid", o_valid, 0);
        check("rst_o_result", o_result, 0);
        check("rst_o_tag", o_tag, 0);
`ifdef MUL_PERF_CNT_EN
        check("rst_count", mul_count, 0);
`endif
        i_rst_n = 1'b1;
        #1;
        check("rst_o_ready", o_ready, 1);
        step();

        // Reference vectors with exact three-cycle latency
        run_one(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd5,  32'h00000000);
        run_one(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd6,  32'hFFFFFFFE);
        run_one(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd7,  32'hFFFFFFFF);
        run_one(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd8,  32'h00000001);
        run_one(2'b00, 32'h80000000, 32'h80000000, 6'd9,  32'h00000000);
        run_one(2'b01, 32'h80000000, 32'h80000000, 6'd10, 32'h40000000);
        run_one(2'b11, 32'h80000000, 32'h80000000, 6'd11, 32'h40000000);
        run_one(2'b10, 32'h80000000, 32'h80000000, 6'd12, 32'hC0000000);
        run_one(2'b01, 32'h80000000, 32'h00000001, 6'd13, 32'hFFFFFFFF);
        run_one(2'b00, 32'hFFFFFFFE, 32'h00000003, 6'd14, 32'hFFFFFFFA);
        step();
        check("ref_drain", q.size(), 0);

        // Back-to-back ops with a five-cycle output stall
        exp1 = model(2'b01, 32'h12345678, 32'hFEDCBA98);
        drive(2'b01, 32'h12345678, 32'hFEDCBA98, 6'd20); step();
        drive(2'b00, 32'h0000FFFF, 32'h0000FFFF, 6'd21); step();
        drive(2'b10, 32'h80000001, 32'h7FFFFFFF, 6'd22); step();
        drive(2'b11, 32'hDEADBEEF, 32'hCAFEBABE, 6'd23);
        i_ready = 1'b0;
        #1;
        check("stall_o_valid", o_valid, 1);
        check("stall_o_ready", o_ready, 0);
        check("stall_result", o_result, exp1);
        check("stall_tag", o_tag, 6'd20);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_hold_valid", o_valid, 1);
            check("stall_hold_ready", o_ready, 0);
            check("stall_hold_result", o_result, exp1);
            check("stall_hold_tag", o_tag, 6'd20);
        end
        i_ready = 1'b1;
        step();
        i_valid = 1'b0;
        repeat (6) step();
        check("stall_drain", q.size(), 0);

        // Flush with three ops in flight, a pending output and a presented op
        drive(2'b00, 32'd3, 32'd5, 6'd30); step();
        drive(2'b00, 32'd4, 32'd5, 6'd31); step();
        drive(2'b00, 32'd6, 32'd5, 6'd32); step();
        drive(2'b00, 32'd9, 32'd9, 6'd33);
        i_ready = 1'b0;
        i_flush = 1'b1;
        #1;
        check("flush_o_ready", o_ready, 0);
        step();
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("flush_no_valid", o_valid, 0);
            step();
        end
        run_one(2'b00, 32'd7, 32'd6, 6'd34, 32'd42);
        step();
        check("flush_drain", q.size(), 0);

        // Asynchronous reset with a result pending at the output
        drive(2'b11, 32'h11111111, 32'h22222222, 6'd40); step();
        drive(2'b11, 32'h33333333, 32'h44444444, 6'd41); step();
        drive(2'b11, 32'h55555555, 32'h66666666, 6'd42); step();
        i_valid = 1'b0;
        i_ready = 1'b0;
        check("pre_rst_valid", o_valid, 1);
        #2;
        i_rst_n = 1'b0;
        q.delete();
        #1;
        check("async_rst_valid", o_valid, 0);
        step();
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_no_valid", o_valid, 0);
        end
`ifdef MUL_PERF_CNT_EN
        check("post_rst_count", mul_count, 0);
`endif

        // Ten retired operations, then a flush while the output is being taken
        for (int i = 0; i < 10; i++) begin
            drive(2'($urandom), $urandom, $urandom, 6'(i));
            step();
        end
        i_valid = 1'b0;
        repeat (4) step();
        check("ten_drain", q.size(), 0);
`ifdef MUL_PERF_CNT_EN
        check("count_ten", mul_count, 10);
`endif
        drive(2'b00, 32'd2, 32'd2, 6'd50);
        step();
        i_valid = 1'b0;
        step();
        step();
        check("flush_ready_pre_valid", o_valid, 1);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        check("flush_ready_valid", o_valid, 0);
`ifdef MUL_PERF_CNT_EN
        check("count_after_flush", mul_count, 10);
        i_rst_n = 1'b0;
        #1;
        check("count_rst", mul_count, 0);
        step();
        i_rst_n = 1'b1;
        step();
`endif

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 40; i++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_op    = 2'($urandom);
            i_rs1   = ($urandom_range(0, 7) < 6) ? corners[$urandom_range(0, 5)] : $urandom;
            i_rs2   = ($urandom_range(0, 7) < 6) ? corners[$urandom_range(0, 5)] : $urandom;
            i_tag   = 6'($urandom);
            step();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (6) step();
        check("rand_drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
